// File: rtl/input_fetch_seq_if.sv
// Bundle for the input-fetch sequencer: control/config, buffer read port and element stream.
// The master modport is the sequencer side; slave is the buffer/consumer/controller side.
interface input_fetch_seq_if #(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned ADDR_WIDTH = 8,
   parameter int unsigned DIM_WIDTH  = 8
);

   logic                  start;
   logic [ADDR_WIDTH-1:0] cfg_base;
   logic [DIM_WIDTH-1:0]  cfg_rows;
   logic [DIM_WIDTH-1:0]  cfg_cols;
   logic [ADDR_WIDTH-1:0] cfg_stride;
   logic [DIM_WIDTH-1:0]  cfg_passes;
   logic                  busy;
   logic                  done;

   logic                  buf_rd_en;
   logic [ADDR_WIDTH-1:0] buf_rd_addr;
   logic [DATA_WIDTH-1:0] buf_rd_data;
   logic                  buf_rd_valid;

   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_WIDTH-1:0] out_data;
   logic                  out_last_col;
   logic                  out_last;

   modport master (
      input  start, cfg_base, cfg_rows, cfg_cols, cfg_stride, cfg_passes,
      input  buf_rd_data, buf_rd_valid, out_ready,
      output busy, done, buf_rd_en, buf_rd_addr,
      output out_valid, out_data, out_last_col, out_last
   );

   modport slave (
      output start, cfg_base, cfg_rows, cfg_cols, cfg_stride, cfg_passes,
      output buf_rd_data, buf_rd_valid, out_ready,
      input  busy, done, buf_rd_en, buf_rd_addr,
      input  out_valid, out_data, out_last_col, out_last
   );

endinterface

// File: rtl/input_fetch_seq.sv
// Input-feature read sequencer: walks a rows x cols tile (repeated per pass) through the
// buffer's 1-cycle read port and streams elements out through a credit-guarded 4-entry FIFO.
module input_fetch_seq #(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned ADDR_WIDTH = 8,
   parameter int unsigned DIM_WIDTH  = 8
) (
   input logic               clk,
   input logic               rst_n,
   input_fetch_seq_if.master bus
);

   localparam logic [DIM_WIDTH-1:0]  DimOne  = 1;
   localparam logic [ADDR_WIDTH-1:0] AddrOne = 1;
   localparam logic [2:0]            Depth   = 3'd4;

   typedef enum logic [1:0] {StIdle, StFetch, StDrain, StFinish} state_e;

   typedef struct packed {
      logic                  last_col;
      logic                  last;
      logic [DATA_WIDTH-1:0] data;
   } entry_t;

   state_e state_q, state_d;

   logic [ADDR_WIDTH-1:0] base_q, base_d, stride_q, stride_d;
   logic [DIM_WIDTH-1:0]  rows_q, rows_d, cols_q, cols_d, passes_q, passes_d;
   logic [DIM_WIDTH-1:0]  row_q, row_d, col_q, col_d, pass_q, pass_d;
   logic [ADDR_WIDTH-1:0] row_addr_q, row_addr_d, addr_q, addr_d;
   logic [2:0]            used_q, used_d;
   logic                  infl_q, infl_d, infl_lc_q, infl_lc_d, infl_l_q, infl_l_d;
   entry_t                fifo_q [4];
   entry_t                fifo_d [4];
   logic [1:0]            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [2:0]            cnt_q, cnt_d;

   logic   accept, zero_dim, rd_en, fifo_valid, pop, push;
   logic   last_col, last_row, last_pass, final_rd;
   entry_t head;

   assign accept    = (state_q == StIdle) && bus.start;
   assign zero_dim  = (bus.cfg_rows == '0) || (bus.cfg_cols == '0);
   assign last_col  = (col_q == cols_q - DimOne);
   assign last_row  = (row_q == rows_q - DimOne);
   assign last_pass = (pass_q == passes_q - DimOne);
   assign final_rd  = rd_en && last_col && last_row && last_pass;
   assign pop       = fifo_valid && bus.out_ready;
   // Data returning for a read issued before a reset is dropped here.
   assign push      = bus.buf_rd_valid && infl_q;

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (bus.start) state_d = zero_dim ? StFinish : StFetch;
         end
         StFetch: begin
            if (final_rd) state_d = StDrain;
         end
         StDrain: begin
            // Leave once the last outstanding element is popped this cycle.
            if (used_d == 3'd0) state_d = StFinish;
         end
         StFinish: state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   always_comb begin
      head             = fifo_q[rd_ptr_q];
      fifo_valid       = (cnt_q != 3'd0);
      rd_en            = (state_q == StFetch) && (used_q < Depth);
      bus.busy         = (state_q != StIdle);
      bus.done         = (state_q == StFinish);
      bus.buf_rd_en    = rd_en;
      bus.buf_rd_addr  = rd_en ? addr_q : '0;
      bus.out_valid    = fifo_valid;
      bus.out_data     = fifo_valid ? head.data : '0;
      bus.out_last_col = fifo_valid && head.last_col;
      bus.out_last     = fifo_valid && head.last;
   end

   // ---------------------------------------------------------------- address walk
   always_comb begin
      base_d     = base_q;
      stride_d   = stride_q;
      rows_d     = rows_q;
      cols_d     = cols_q;
      passes_d   = passes_q;
      row_d      = row_q;
      col_d      = col_q;
      pass_d     = pass_q;
      row_addr_d = row_addr_q;
      addr_d     = addr_q;
      if (accept) begin
         base_d     = bus.cfg_base;
         stride_d   = bus.cfg_stride;
         rows_d     = bus.cfg_rows;
         cols_d     = bus.cfg_cols;
         passes_d   = (bus.cfg_passes == '0) ? DimOne : bus.cfg_passes;
         row_d      = '0;
         col_d      = '0;
         pass_d     = '0;
         row_addr_d = bus.cfg_base;
         addr_d     = bus.cfg_base;
      end else if (rd_en) begin
         if (!last_col) begin
            col_d  = col_q + DimOne;
            addr_d = addr_q + AddrOne;
         end else begin
            col_d = '0;
            if (last_row) begin
               row_d      = '0;
               pass_d     = pass_q + DimOne;
               row_addr_d = base_q;
               addr_d     = base_q;
            end else begin
               row_d      = row_q + DimOne;
               row_addr_d = row_addr_q + stride_q;
               addr_d     = row_addr_q + stride_q;
            end
         end
      end
   end

   // ---------------------------------------------------------------- credits and FIFO
   always_comb begin
      used_d = used_q;
      unique case ({rd_en, pop})
         2'b10:   used_d = used_q + 3'd1;
         2'b01:   used_d = used_q - 3'd1;
         default: used_d = used_q;
      endcase

      // Tags are fixed at issue time and ride alongside the read.
      infl_d    = rd_en;
      infl_lc_d = rd_en ? last_col : infl_lc_q;
      infl_l_d  = rd_en ? (last_col && last_row) : infl_l_q;

      fifo_d   = fifo_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push) begin
         fifo_d[wr_ptr_q] = '{last_col: infl_lc_q, last: infl_l_q, data: bus.buf_rd_data};
         wr_ptr_d         = wr_ptr_q + 2'd1;
      end
      if (pop) rd_ptr_d = rd_ptr_q + 2'd1;

      cnt_d = cnt_q;
      unique case ({push, pop})
         2'b10:   cnt_d = cnt_q + 3'd1;
         2'b01:   cnt_d = cnt_q - 3'd1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         base_q     <= '0;
         stride_q   <= '0;
         rows_q     <= '0;
         cols_q     <= '0;
         passes_q   <= '0;
         row_q      <= '0;
         col_q      <= '0;
         pass_q     <= '0;
         row_addr_q <= '0;
         addr_q     <= '0;
         used_q     <= '0;
         infl_q     <= 1'b0;
         infl_lc_q  <= 1'b0;
         infl_l_q   <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         cnt_q      <= '0;
         for (int i = 0; i < 4; i++) fifo_q[i] <= '0;
      end else begin
         base_q     <= base_d;
         stride_q   <= stride_d;
         rows_q     <= rows_d;
         cols_q     <= cols_d;
         passes_q   <= passes_d;
         row_q      <= row_d;
         col_q      <= col_d;
         pass_q     <= pass_d;
         row_addr_q <= row_addr_d;
         addr_q     <= addr_d;
         used_q     <= used_d;
         infl_q     <= infl_d;
         infl_lc_q  <= infl_lc_d;
         infl_l_q   <= infl_l_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         cnt_q      <= cnt_d;
         for (int i = 0; i < 4; i++) fifo_q[i] <= fifo_d[i];
      end
   end

endmodule

// File: tb/tb_input_fetch_seq.sv
// Directed bench for input_fetch_seq: per-cycle trace of the ports, then each run is checked
// against hand-written address/tag tables and a preloaded buffer model.
module tb_input_fetch_seq;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   input_fetch_seq_if bus ();

   input_fetch_seq dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct packed {
      logic        busy;
      logic        done;
      logic        rd_en;
      logic [7:0]  addr;
      logic        valid;
      logic        ready;
      logic [15:0] data;
      logic        lc;
      logic        l;
   } tr_t;

   tr_t         trace [0:4095];
   int          cyc = 0;
   int          total = 0;
   int          bad = 0;
   logic [15:0] mem [0:255];
   logic        ready_lvl;
   logic        ready_mode;
   logic [3:0]  pat = 4'b1001;

   function automatic logic [15:0] mdl(input logic [7:0] a);
      return {a ^ 8'h5A, a};
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // Buffer model with 1-cycle read latency
   always @(posedge clk) begin
      if (bus.buf_rd_en) bus.buf_rd_data <= mem[bus.buf_rd_addr];
      bus.buf_rd_valid <= bus.buf_rd_en;
   end

   assign bus.out_ready = ready_mode ? pat[cyc[1:0]] : ready_lvl;

   always @(negedge clk) begin
      trace[cyc[11:0]] <= {bus.busy, bus.done, bus.buf_rd_en, bus.buf_rd_addr, bus.out_valid,
                           bus.out_ready, bus.out_data, bus.out_last_col, bus.out_last};
   end

   function automatic tr_t tr(input int c);
      return trace[c[11:0]];
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic launch(input logic [7:0] base, input logic [7:0] rows, input logic [7:0] cols,
                         input logic [7:0] stride, input logic [7:0] passes, output int t);
      @(posedge clk); #1;
      bus.cfg_base   = base;
      bus.cfg_rows   = rows;
      bus.cfg_cols   = cols;
      bus.cfg_stride = stride;
      bus.cfg_passes = passes;
      bus.start      = 1'b1;
      t = cyc;
      @(posedge clk); #1;
      bus.start = 1'b0;
   endtask

   // mode 1: stray start plus config change mid-run; mode 2: start during the done cycle
   task automatic run_chk(input string tag, input logic [7:0] base, input logic [7:0] rows,
                          input logic [7:0] cols, input logic [7:0] stride,
                          input logic [7:0] passes, input int n, input logic [63:0] ea,
                          input logic [7:0] elc, input logic [7:0] el, input int edone,
                          input int mode);
      int   t, dc, nr, np, nd, viol, outs, mx;
      bit   found;
      tr_t  a, b;
      launch(base, rows, cols, stride, passes, t);
      if (mode == 1) begin
         repeat (2) @(posedge clk);
         #1;
         bus.cfg_base = 8'h80;
         bus.cfg_rows = 8'd1;
         bus.cfg_cols = 8'd1;
         bus.start    = 1'b1;
         @(posedge clk); #1;
         bus.start = 1'b0;
      end
      found = 1'b0;
      dc    = 0;
      for (int i = 0; i < 300 && !found; i++) begin
         @(negedge clk); #1;
         if (bus.done) begin
            found = 1'b1;
            dc    = cyc;
         end
      end
      chk({tag, " done_seen"}, 32'(found), 32'd1);
      if (!found) dc = cyc;
      if (mode == 2 && found) begin
         bus.start = 1'b1;
         @(posedge clk); #1;
         bus.start = 1'b0;
      end
      repeat (3) @(posedge clk);
      #1;

      chk({tag, " busy_before"}, 32'(tr(t).busy), 32'd0);
      chk({tag, " rd_en_t1"}, 32'(tr(t + 1).rd_en), 32'(n != 0));
      if (n != 0) chk({tag, " addr_t1"}, 32'(tr(t + 1).addr), 32'(ea[7:0]));
      nr = 0; np = 0; nd = 0; viol = 0; outs = 0; mx = 0;
      for (int c = t + 1; c <= dc + 1; c++) begin
         a = tr(c);
         b = tr(c + 1);
         if (a.rd_en) begin
            if (nr < 8) chk($sformatf("%s addr%0d", tag, nr), 32'(a.addr), 32'(ea[8*nr +: 8]));
            nr++;
            outs++;
         end
         if (a.valid && a.ready) begin
            if (np < 8) begin
               chk($sformatf("%s data%0d", tag, np), 32'(a.data), 32'(mdl(ea[8*np +: 8])));
               chk($sformatf("%s lastcol%0d", tag, np), 32'(a.lc), 32'(elc[np]));
               chk($sformatf("%s last%0d", tag, np), 32'(a.l), 32'(el[np]));
            end
            np++;
            outs--;
         end
         if (outs > mx) mx = outs;
         if (a.done) nd++;
         if (c <= dc && a.valid && !a.ready) begin
            if (!b.valid || b.data !== a.data || b.lc !== a.lc || b.l !== a.l) viol++;
         end
      end
      chk({tag, " rd_count"}, 32'(nr), 32'(n));
      chk({tag, " pop_count"}, 32'(np), 32'(n));
      chk({tag, " done_count"}, 32'(nd), 32'd1);
      chk({tag, " hold_viol"}, 32'(viol), 32'd0);
      chk({tag, " credit_le4"}, 32'(mx <= 4), 32'd1);
      if (edone >= 0) chk({tag, " done_cycle"}, 32'(dc - t), 32'(edone));
      chk({tag, " busy_at_done"}, 32'(tr(dc).busy), 32'd1);
      chk({tag, " busy_after1"}, 32'(tr(dc + 1).busy), 32'd0);
      chk({tag, " busy_after2"}, 32'(tr(dc + 2).busy), 32'd0);
      if (mode == 0 && n != 0 && !ready_mode) begin
         chk({tag, " valid_t2"}, 32'(tr(t + 2).valid), 32'd0);
         chk({tag, " valid_t3"}, 32'(tr(t + 3).valid), 32'd1);
      end
   endtask

   localparam logic [63:0] EaA = {8'h1A, 8'h19, 8'h18, 8'h12, 8'h11, 8'h10};

   initial begin
      int t;
      for (int i = 0; i < 256; i++) mem[i] = mdl(8'(i));
      rst_n          = 1'b0;
      bus.start      = 1'b0;
      bus.cfg_base   = '0;
      bus.cfg_rows   = '0;
      bus.cfg_cols   = '0;
      bus.cfg_stride = '0;
      bus.cfg_passes = '0;
      ready_lvl      = 1'b1;
      ready_mode     = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      chk("rst busy", 32'(bus.busy), 32'd0);
      chk("rst done", 32'(bus.done), 32'd0);
      chk("rst rd_en", 32'(bus.buf_rd_en), 32'd0);
      chk("rst rd_addr", 32'(bus.buf_rd_addr), 32'd0);
      chk("rst out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst out_data", 32'(bus.out_data), 32'd0);
      chk("rst last_col", 32'(bus.out_last_col), 32'd0);
      chk("rst last", 32'(bus.out_last), 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      run_chk("A tile2x3", 8'h10, 8'd2, 8'd3, 8'h08, 8'd1, 6, EaA, 8'h24, 8'h20, 9, 0);
      run_chk("B wrap", 8'hFE, 8'd1, 8'd4, 8'h00, 8'd0, 4,
              64'({8'h01, 8'h00, 8'hFF, 8'hFE}), 8'h08, 8'h08, 7, 0);
      ready_mode = 1'b1;
      run_chk("C stall", 8'h10, 8'd2, 8'd3, 8'h08, 8'd1, 6, EaA, 8'h24, 8'h20, -1, 0);
      ready_mode = 1'b0;
      run_chk("D passes", 8'h40, 8'd1, 8'd2, 8'h05, 8'd3, 6,
              64'({8'h41, 8'h40, 8'h41, 8'h40, 8'h41, 8'h40}), 8'h2A, 8'h2A, 9, 0);
      run_chk("E zero_rows", 8'h20, 8'd0, 8'd3, 8'h01, 8'd1, 0, 64'h0, 8'h00, 8'h00, 1, 0);
      run_chk("F restart_ign", 8'h10, 8'd2, 8'd3, 8'h08, 8'd1, 6, EaA, 8'h24, 8'h20, 9, 1);
      run_chk("G finish_start", 8'h10, 8'd2, 8'd3, 8'h08, 8'd1, 6, EaA, 8'h24, 8'h20, 9, 2);

      // Reset with 3 elements buffered and one read still in flight
      ready_lvl = 1'b0;
      launch(8'h10, 8'd2, 8'd3, 8'h08, 8'd1, t);
      repeat (4) @(posedge clk);
      #1;
      chk("R pre valid", 32'(bus.out_valid), 32'd1);
      chk("R pre data", 32'(bus.out_data), 32'(mdl(8'h10)));
      rst_n = 1'b0;
      #1;
      chk("R busy", 32'(bus.busy), 32'd0);
      chk("R done", 32'(bus.done), 32'd0);
      chk("R rd_en", 32'(bus.buf_rd_en), 32'd0);
      chk("R rd_addr", 32'(bus.buf_rd_addr), 32'd0);
      chk("R out_valid", 32'(bus.out_valid), 32'd0);
      chk("R out_data", 32'(bus.out_data), 32'd0);
      chk("R last_col", 32'(bus.out_last_col), 32'd0);
      chk("R last", 32'(bus.out_last), 32'd0);
      #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("R discard valid", 32'(bus.out_valid), 32'd0);
      chk("R post busy", 32'(bus.busy), 32'd0);
      @(posedge clk); #1;
      chk("R idle valid", 32'(bus.out_valid), 32'd0);
      ready_lvl = 1'b1;
      run_chk("H after_rst", 8'h10, 8'd2, 8'd3, 8'h08, 8'd1, 6, EaA, 8'h24, 8'h20, 9, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/input_fetch_seq.md
# input_fetch_seq

Read sequencer for the input-feature buffer. On `start` it walks a 2-D tile (rows × cols, with configurable row stride and base) through the buffer's synchronous read port. It replays the tile a configurable number of passes, and delivers elements to the matrix-multiply array as a valid/ready stream. A 4-entry credit-controlled skid FIFO absorbs the buffer's 1-cycle read latency, so consumer backpressure never loses data.

## Interface
- `DATA_WIDTH`, 16, element width (Q8.8)
- `ADDR_WIDTH`, 8, buffer address width
- `DIM_WIDTH`, 8, width of rows/cols/passes counters
- `clk`  in  1  clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `start`  in  1  start pulse; sampled only in IDLE
- `cfg_base`  in  ADDR_WIDTH  address of element (0,0)
- `cfg_rows`  in  DIM_WIDTH  tile rows
- `cfg_cols`  in  DIM_WIDTH  tile columns
- `cfg_stride`  in  ADDR_WIDTH  address step between row starts
- `cfg_passes`  in  DIM_WIDTH  tile replays; 0 treated as 1
- `busy`  out  1  high from accepted start until done
- `done`  out  1  one-cycle pulse at completion
- `buf_rd_en`  out  1  buffer read enable
- `buf_rd_addr`  out  ADDR_WIDTH  buffer read address
- `buf_rd_data`  in  DATA_WIDTH  buffer data, valid the cycle after `buf_rd_en`
- `buf_rd_valid`  in  1  buffer data-valid flag
- `out_valid`  out  1  stream valid
- `out_ready`  in  1  stream ready from MAC array
- `out_data`  out  DATA_WIDTH  element
- `out_last_col`  out  1  element is the last column of its row
- `out_last`  out  1  element is the last of a pass

## Operation
- Config is latched on the accepted start and held for the whole run. Config-port changes during a run have no effect.
- States:
  - IDLE → FETCH on `start`, provided rows≠0 and cols≠0.
  - IDLE → FINISH on `start` when rows=0 or cols=0. No reads are issued in this case.
  - FETCH → DRAIN after the final read of the final pass is issued.
  - DRAIN → FINISH when the FIFO is empty and nothing is in flight.
  - FINISH → IDLE unconditionally. `done`=1 in the FINISH cycle.
- Element order: pass-major, then row, then column. Address = base + r·stride + c, modulo 2^ADDR_WIDTH; wrap-around is legal and silent.
  - Address is computed incrementally: a row-start register adds `stride`, a column offset adds 1. No multiplier.
- Credits: `used` counts reads issued and not yet popped, range 0..4.
  - A read is issued in a FETCH cycle only if `used` < 4.
  - `used` increments on issue and decrements on pop (out_valid & out_ready). On a simultaneous issue and pop, `used` is unchanged.
- FIFO: depth 4. Written when `buf_rd_valid`=1, popped on handshake.
  - `out_last_col` and `out_last` are tagged at issue time and travel with the data.
  - FIFO overflow cannot occur because of the credit rule.
- `start` while busy is ignored. A `start` in the FINISH cycle is also ignored.
- Asynchronous reset mid-run:
  - Returns to IDLE and empties the FIFO.
  - Clears all counters.
  - A buffer read in flight at reset is discarded.

## Timing
- Reset values: `busy`=0, `done`=0, `buf_rd_en`=0, `buf_rd_addr`=0, `out_valid`=0, `out_data`=0, `out_last_col`=0, `out_last`=0.
- `start` accepted at cycle T:
  - `busy`=1 from T+1.
  - First `buf_rd_en` at T+1 with addr=base.
  - FIFO written at the end of T+2.
  - First `out_valid` at T+3.
- With `out_ready` held high: one read and one output per cycle, no bubbles. For N = rows·cols·passes elements:
  - Last pop at T+2+N.
  - `done` pulse at T+3+N.
  - `busy` falls at T+4+N.
- Zero-dimension start at T: `done` at T+1, `busy`=1 only in T+1.
- `out_data` and the tag outputs are stable while `out_valid`=1 and `out_ready`=0.

## Test plan
- Base 0x10, rows 2, cols 3, stride 8, passes 1, ready high -> addresses 10,11,12,18,19,1A. `out_last_col` on the 3rd and 6th elements, `out_last` on the 6th. `done` at T+9.
- Base 0xFE, rows 1, cols 4, stride 0 -> addresses FE,FF,00,01, wrapped. Data matches preloaded buffer contents.
- Same 2×3 tile with `out_ready` toggling 1-0-0-1 -> at most 4 outstanding. No element is dropped or duplicated; data holds while stalled.
- passes 3 on a 1×2 tile -> 6 elements; `out_last` on elements 2, 4 and 6; a single `done` pulse.
- rows 0 -> no `buf_rd_en`; `done` at T+1. A second `start` during a run is ignored, and the sequence is unchanged.
- Reset asserted mid-run with 3 elements buffered -> all outputs at reset values immediately. After release, a new `start` runs cleanly from the first element.
